// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl_if
// Brief    : Data/control and pin-side bundle for the 7-segment scan driver.
// Revision : 1.0
// ============================================================================
interface seg7_scan_ctrl_if #(
    parameter int NDIG = 4
);
    logic                load;
    logic [4*NDIG-1:0]   dat;
    logic [NDIG-1:0]     dp;
    logic                blank_lz;
    logic [2:0]          bright;
    logic [7:0]          seg;
    logic [NDIG-1:0]     an;
    logic                frame_done;

    modport master (
        output load, dat, dp, blank_lz, bright,
        input  seg, an, frame_done
    );

    modport slave (
        input  load, dat, dp, blank_lz, bright,
        output seg, an, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : Multiplexed common-anode 7-segment driver with PWM brightness,
//            leading-zero blanking and frame-synchronous double buffering.
// Revision : 1.0
// ============================================================================
module seg7_scan_ctrl #(
    parameter int NDIG        = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int HEX_MODE    = 1,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic             clk,
    input  logic             rst,
    seg7_scan_ctrl_if.slave  bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(NDIG);
    localparam logic [7:0]      SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NDIG-1:0] AN_OFF  = (AN_ACT_LOW  != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

    logic [PW-1:0]     presc_q, presc_d;
    logic [2:0]        sub_q, sub_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [4*NDIG-1:0] shd_dat_q, shd_dat_d;
    logic [NDIG-1:0]   shd_dp_q, shd_dp_d;
    logic              pend_q, pend_d;
    logic [4*NDIG-1:0] dsp_dat_q, dsp_dat_d;
    logic [NDIG-1:0]   dsp_dp_q, dsp_dp_d;
    logic [7:0]        seg_q, seg_d;
    logic [NDIG-1:0]   an_q, an_d;

    logic              tick;
    logic              slot_end;
    logic              last_dig;
    logic              frame_end;
    logic [NDIG-1:0]   lz;
    logic              zero_run;
    logic [3:0]        nib;
    logic              dp_bit;
    logic              lz_bit;
    logic              lit;
    logic [7:0]        seg_al;
    logic [NDIG-1:0]   onehot;

    // Active-low a..g pattern; bit 6 = g, bit 0 = a.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            default: p = 7'h0E;
        endcase
        if (HEX_MODE == 0 && n >= 4'd10) begin
            p = 7'h7F;
        end
        return p;
    endfunction

    always_comb begin
        tick      = (presc_q == PW'(SCAN_DIV - 1));
        slot_end  = tick && (sub_q == 3'd7);
        last_dig  = (dig_q == DW'(NDIG - 1));
        frame_end = slot_end && last_dig;

        presc_d = tick ? '0 : presc_q + 1'b1;
        sub_d   = tick ? sub_q + 3'd1 : sub_q;
        dig_d   = dig_q;
        if (slot_end) begin
            dig_d = last_dig ? '0 : dig_q + 1'b1;
        end
    end

    // A load landing on the boundary cycle goes straight to the display buffer.
    always_comb begin
        shd_dat_d = shd_dat_q;
        shd_dp_d  = shd_dp_q;
        pend_d    = pend_q;
        dsp_dat_d = dsp_dat_q;
        dsp_dp_d  = dsp_dp_q;
        if (bus.load) begin
            shd_dat_d = bus.dat;
            shd_dp_d  = bus.dp;
            pend_d    = 1'b1;
        end
        if (frame_end) begin
            if (bus.load) begin
                dsp_dat_d = bus.dat;
                dsp_dp_d  = bus.dp;
            end else if (pend_q) begin
                dsp_dat_d = shd_dat_q;
                dsp_dp_d  = shd_dp_q;
            end
            pend_d = 1'b0;
        end
    end

    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int k = NDIG - 1; k >= 0; k--) begin
            zero_run = zero_run && (dsp_dat_q[4*k +: 4] == 4'd0);
            lz[k]    = zero_run && (k != 0);
        end

        nib    = dsp_dat_q[3:0];
        dp_bit = dsp_dp_q[0];
        lz_bit = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (dig_q == DW'(k)) begin
                nib    = dsp_dat_q[4*k +: 4];
                dp_bit = dsp_dp_q[k];
                lz_bit = lz[k];
            end
        end

        lit    = (sub_q <= bus.bright) && !(bus.blank_lz && lz_bit);
        seg_al = {~dp_bit, decode(nib)};
        onehot = '0;
        onehot[dig_q] = 1'b1;

        seg_d = SEG_OFF;
        an_d  = AN_OFF;
        if (lit) begin
            seg_d = (SEG_ACT_LOW != 0) ? seg_al : ~seg_al;
            an_d  = (AN_ACT_LOW  != 0) ? ~onehot : onehot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            sub_q     <= '0;
            dig_q     <= '0;
            shd_dat_q <= '0;
            shd_dp_q  <= '0;
            pend_q    <= 1'b0;
            dsp_dat_q <= '0;
            dsp_dp_q  <= '0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
        end else begin
            presc_q   <= presc_d;
            sub_q     <= sub_d;
            dig_q     <= dig_d;
            shd_dat_q <= shd_dat_d;
            shd_dp_q  <= shd_dp_d;
            pend_q    <= pend_d;
            dsp_dat_q <= dsp_dat_d;
            dsp_dp_q  <= dsp_dp_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_end;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Scoreboard bench for seg7_scan_ctrl, hex and BCD-limited decode.
// Revision : 1.0
// ============================================================================
module tb_seg7_scan_ctrl;
    localparam int NDIG     = 4;
    localparam int SCAN_DIV = 4;
    localparam int SLOT     = 8 * SCAN_DIV;
    localparam logic [7:0] SEG_TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg_hex;
        logic [7:0] seg_dec;
        int         on;
    } slot_t;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        load_r   = 1'b0;
    logic        blz_r    = 1'b0;
    logic [15:0] dat_r    = '0;
    logic [3:0]  dp_r     = '0;
    logic [2:0]  bright_r = 3'd7;

    slot_t sb_q[$];
    int    n_checks    = 0;
    int    n_errors    = 0;
    int    cyc_cnt     = 0;
    int    last_period = 0;

    seg7_scan_ctrl_if #(.NDIG(NDIG)) bus_hex ();
    seg7_scan_ctrl_if #(.NDIG(NDIG)) bus_dec ();

    assign bus_hex.load     = load_r;
    assign bus_hex.dat      = dat_r;
    assign bus_hex.dp       = dp_r;
    assign bus_hex.blank_lz = blz_r;
    assign bus_hex.bright   = bright_r;
    assign bus_dec.load     = load_r;
    assign bus_dec.dat      = dat_r;
    assign bus_dec.dp       = dp_r;
    assign bus_dec.blank_lz = blz_r;
    assign bus_dec.bright   = bright_r;

    seg7_scan_ctrl #(
        .NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .HEX_MODE(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
    ) u_dut_hex (
        .clk (clk),
        .rst (rst),
        .bus (bus_hex)
    );

    seg7_scan_ctrl #(
        .NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .HEX_MODE(0), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
    ) u_dut_dec (
        .clk (clk),
        .rst (rst),
        .bus (bus_dec)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            cyc_cnt <= 0;
        end else if (bus_hex.frame_done) begin
            last_period <= cyc_cnt + 1;
            cyc_cnt     <= 0;
        end else begin
            cyc_cnt <= cyc_cnt + 1;
        end
    end

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected per-digit appearance of one frame, derived from the load data.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] p,
                              input logic blz, input logic [2:0] br);
        bit         zero_above;
        bit         blanked [4];
        logic [3:0] nib;
        slot_t      s;
        zero_above = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            zero_above = zero_above && (d[4*k +: 4] == 4'd0);
            blanked[k] = blz && zero_above && (k != 0);
        end
        for (int k = 0; k < 4; k++) begin
            nib       = d[4*k +: 4];
            s.an      = ~(4'b0001 << k);
            s.seg_hex = SEG_TBL[nib];
            s.seg_dec = (nib >= 4'd10) ? 8'hFF : SEG_TBL[nib];
            if (p[k]) begin
                s.seg_hex[7] = 1'b0;
                s.seg_dec[7] = 1'b0;
            end
            s.on = blanked[k] ? 0 : (int'(br) + 1) * SCAN_DIV;
            sb_q.push_back(s);
        end
    endtask

    // Entered at the first output cycle of a frame; leaves at the next one.
    task automatic check_frame(input string fname);
        slot_t s;
        int    on_h, bad_h, on_d, bad_d, order;
        bit    off_seen;
        for (int k = 0; k < 4; k++) begin
            on_h = 0; bad_h = 0; on_d = 0; bad_d = 0; order = 0; off_seen = 1'b0;
            if (sb_q.size() == 0) begin
                check_value({fname, "_sb_empty"}, 1, 0);
                s = '{an: 4'hF, seg_hex: 8'hFF, seg_dec: 8'hFF, on: 0};
            end else begin
                s = sb_q.pop_front();
            end
            for (int c = 0; c < SLOT; c++) begin
                if (bus_hex.an == s.an && bus_hex.seg == s.seg_hex) begin
                    on_h++;
                    if (off_seen) order++;
                end else if (bus_hex.an == 4'hF && bus_hex.seg == 8'hFF) begin
                    off_seen = 1'b1;
                end else begin
                    bad_h++;
                end
                if (bus_dec.an == s.an && bus_dec.seg == s.seg_dec) on_d++;
                else if (!(bus_dec.an == 4'hF && bus_dec.seg == 8'hFF)) bad_d++;
                @(posedge clk);
                #1;
            end
            check_value($sformatf("%s_d%0d_on", fname, k), on_h, s.on);
            check_value($sformatf("%s_d%0d_bad", fname, k), bad_h, 0);
            check_value($sformatf("%s_d%0d_order", fname, k), order, 0);
            check_value($sformatf("%s_d%0d_dec_on", fname, k), on_d, s.on);
            check_value($sformatf("%s_d%0d_dec_bad", fname, k), bad_d, 0);
        end
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        dat_r  = d;
        dp_r   = p;
        load_r = 1'b1;
        @(negedge clk);
        load_r = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_hex.frame_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_value(tag, int'(bus_hex.frame_done), 1);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_seg", int'(bus_hex.seg), 8'hFF);
        check_value("rst_an", int'(bus_hex.an), 4'hF);
        check_value("rst_fd", int'(bus_hex.frame_done), 0);
        check_value("rst_dec_seg", int'(bus_dec.seg), 8'hFF);
        rst = 1'b0;

        pulse_load(16'h12AF, 4'b0000);
        wait_fd("sync_fd");
        @(posedge clk);
        @(posedge clk);
        #1;

        push_frame(16'h12AF, 4'b0000, 1'b0, 3'd7);
        check_frame("f1_hex");

        bright_r = 3'd2;
        push_frame(16'h12AF, 4'b0000, 1'b0, 3'd2);
        check_frame("f2_dim");
        check_value("period", last_period, 8 * SCAN_DIV * NDIG);

        bright_r = 3'd7;
        blz_r    = 1'b1;
        push_frame(16'h12AF, 4'b0000, 1'b1, 3'd7);
        fork
            check_frame("f3_lz_nz");
            pulse_load(16'h0050, 4'b0100);
        join

        push_frame(16'h0050, 4'b0100, 1'b1, 3'd7);
        fork
            check_frame("f4_lz");
            pulse_load(16'h0000, 4'b0000);
        join

        push_frame(16'h0000, 4'b0000, 1'b1, 3'd7);
        fork
            check_frame("f5_zero");
            begin
                repeat (20) @(negedge clk);
                pulse_load(16'h1111, 4'b0000);
                repeat (40) @(negedge clk);
                pulse_load(16'h2222, 4'b0000);
            end
        join

        push_frame(16'h2222, 4'b0000, 1'b1, 3'd7);
        fork
            check_frame("f6_last");
            begin
                wait_fd("bnd_fd");
                dat_r  = 16'h9999;
                dp_r   = 4'b0000;
                load_r = 1'b1;
                @(negedge clk);
                load_r = 1'b0;
            end
        join

        push_frame(16'h9999, 4'b0000, 1'b1, 3'd7);
        fork
            check_frame("f7_bypass");
            pulse_load(16'hBBBB, 4'b0000);
        join

        push_frame(16'hBBBB, 4'b0000, 1'b1, 3'd7);
        check_frame("f8_b");

        blz_r = 1'b0;
        repeat (10) @(negedge clk);
        pulse_load(16'h3333, 4'b0000);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_value("arst_seg", int'(bus_hex.seg), 8'hFF);
        check_value("arst_an", int'(bus_hex.an), 4'hF);
        check_value("arst_fd", int'(bus_hex.frame_done), 0);
        check_value("arst_dec_an", int'(bus_dec.an), 4'hF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        push_frame(16'h0000, 4'b0000, 1'b0, 3'd7);
        check_frame("r1");
        push_frame(16'h0000, 4'b0000, 1'b0, 3'd7);
        check_frame("r2_nopend");
        check_value("period_rst", last_period, 8 * SCAN_DIV * NDIG);
        check_value("sb_left", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
